mod_rst_seq: RTL and testbench

Reset sequencer directly downstream of the 48 MHz PLL. It clocks on the PLL output, consumes the raw PLL lock flag, and filters that flag for stability. It then releases N_OUT active-low domain resets in a fixed staged order and flags system-ready. Any lock loss or external reset immediately re-asserts every downstream reset.

---
 rtl/mod_rst_seq_pkg.sv | 27 ++
 rtl/mod_rst_seq_sync.sv | 35 +++
 rtl/mod_rst_seq.sv | 186 ++++++++++++++++++
 tb/tb_mod_rst_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and constants for the mod_rst_seq reset sequencer.
//   state_t          : 2-bit FSM state encoding (also visible on o_state)
//   LOCK_CYCLES_DEF  : default lock-stability filter length
//   max_int()        : helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package rst_seq_pkg;

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_FILTER    = 2'd1,
      S_RELEASE   = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   localparam int LOCK_CYCLES_DEF = 1024;

   function automatic int max_int(input int a, input int b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/mod_rst_seq_sync.sv
// -----------------------------------------------------------------------------
// mod_sync
// N-stage single-bit synchronizer, asynchronous active-low reset to 0.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset (clears every stage)
//   i_d     : asynchronous input bit
//   o_q     : synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module mod_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] sync_q;

   if (STAGES < 2) begin : g_param_check
      $error("mod_sync: STAGES must be at least 2");
   end

   // Synchronizer shift chain; stage 0 is the metastability-exposed flop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], i_d};
      end
   end

   assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/mod_rst_seq.sv
// -----------------------------------------------------------------------------
// mod_rst_seq
// Reset sequencer behind the 48 MHz PLL. Synchronizes and filters the raw PLL
// lock flag, then releases N_OUT active-low domain resets one STAGE_GAP apart
// (bit 0 first) and raises o_ready. Losing lock drops every reset at once and
// restarts the whole sequence.
//   i_clk        : PLL output clock
//   i_rst_n      : asynchronous active-low reset (deassertion synchronized)
//   i_pll_locked : raw PLL lock flag, asynchronous to i_clk
//   o_rst_n      : staged domain resets, active-low, bit 0 released first
//   o_ready      : all resets released and lock stable
//   o_state      : current FSM state (debug)
//   o_loss_cnt   : saturating count of lock losses from S_RUN
//                  (only when RST_SEQ_LOSS_CNT_EN is defined)
// -----------------------------------------------------------------------------
module mod_rst_seq
   import rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
   parameter int N_OUT       = 2,
   parameter int STAGE_GAP   = 16,
   parameter int LOSS_CNT_W  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_pll_locked,
   output logic [N_OUT-1:0]      o_rst_n,
   output logic                  o_ready,
   output logic [1:0]            o_state
`ifdef RST_SEQ_LOSS_CNT_EN
   ,
   output logic [LOSS_CNT_W-1:0] o_loss_cnt
`endif
);

   // One extra bit so the counter can never wrap inside a state.
   localparam int CNT_W = $clog2(max_int(LOCK_CYCLES, STAGE_GAP)) + 1;
   localparam logic [N_OUT-1:0] REL_FIRST = N_OUT'(1);

   if (SYNC_STAGES < 2 || LOCK_CYCLES < 1 || N_OUT < 1 || STAGE_GAP < 1 ||
       LOSS_CNT_W < 1) begin : g_param_check
      $error("mod_rst_seq: illegal parameter set");
   end

   logic              lock_s;
   logic              run_en_s;
   logic [N_OUT-1:0]  rel_next_s;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_OUT-1:0]  rst_q, rst_d;
   logic              ready_q, ready_d;

   // Lock flag into the i_clk domain.
   mod_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_pll_locked),
      .o_q     (lock_s)
   );

   // Reset-deassert synchronizer: goes high SYNC_STAGES edges after i_rst_n rises.
   mod_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (1'b1),
      .o_q     (run_en_s)
   );

   // Next release pattern: shift one more low-order one into the released run.
   assign rel_next_s = (rst_q << 1) | REL_FIRST;

   // Next-state, counter and output logic for the sequencing FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rst_d   = rst_q;
      ready_d = 1'b0;
      if (!run_en_s) begin
         state_d = S_WAIT_LOCK;
         cnt_d   = '0;
         rst_d   = '0;
      end else begin
         case (state_q)
            S_WAIT_LOCK: begin
               cnt_d = '0;
               rst_d = '0;
               if (lock_s) begin
                  state_d = S_FILTER;
               end else begin
                  state_d = S_WAIT_LOCK;
               end
            end
            S_FILTER: begin
               if (!lock_s) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
                  rst_d   = '0;
               end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                  cnt_d   = '0;
                  rst_d   = REL_FIRST;
                  state_d = (N_OUT == 1) ? S_RUN : S_RELEASE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_RELEASE: begin
               // Loss is tested first so it beats a coincident stage release.
               if (!lock_s) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
                  rst_d   = '0;
               end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                  cnt_d   = '0;
                  rst_d   = rel_next_s;
                  state_d = rel_next_s[N_OUT-1] ? S_RUN : S_RELEASE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_RUN: begin
               cnt_d = '0;
               if (!lock_s) begin
                  state_d = S_WAIT_LOCK;
                  rst_d   = '0;
               end else begin
                  rst_d   = '1;
                  ready_d = 1'b1;
               end
            end
            default: begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
               rst_d   = '0;
            end
         endcase
      end
   end

   // FSM state, counter and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_WAIT_LOCK;
         cnt_q   <= '0;
         rst_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
      end
   end

   assign o_rst_n = rst_q;
   assign o_ready = ready_q;
   assign o_state = state_q;

`ifdef RST_SEQ_LOSS_CNT_EN
   logic [LOSS_CNT_W-1:0] loss_q, loss_d;

   // Count only S_RUN -> S_WAIT_LOCK transitions, saturating at all-ones.
   always_comb begin
      loss_d = loss_q;
      if (run_en_s && (state_q == S_RUN) && !lock_s &&
          (loss_q != {LOSS_CNT_W{1'b1}})) begin
         loss_d = loss_q + LOSS_CNT_W'(1);
      end else begin
         loss_d = loss_q;
      end
   end

   // Loss counter register, cleared only by i_rst_n.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         loss_q <= '0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign o_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_mod_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_mod_rst_seq
// Self-checking bench for mod_rst_seq (SYNC_STAGES=2, LOCK_CYCLES=8, N_OUT=2,
// STAGE_GAP=4, LOSS_CNT_W=2). Table of timed lock vectors, hand sequences for
// asynchronous reset and the optional loss counter, then random lock toggling
// compared with a run-length reference model.
// -----------------------------------------------------------------------------
module tb_mod_rst_seq;

   localparam int SYNC  = 2;
   localparam int LOCK  = 8;
   localparam int NOUT  = 2;
   localparam int GAP   = 4;
   localparam int LOSSW = 2;
   localparam int LOSS_MAX = (1 << LOSSW) - 1;

   // Run length (edges with a synchronized lock seen) at which things happen.
   localparam int REL0_R = 1 + LOCK;
   localparam int RUN_R  = REL0_R + (NOUT - 1) * GAP;

   logic             clk;
   logic             rst_n;
   logic             lock;
   logic [NOUT-1:0]  o_rst_n;
   logic             o_ready;
   logic [1:0]       o_state;
`ifdef RST_SEQ_LOSS_CNT_EN
   logic [LOSSW-1:0] o_loss_cnt;
`endif

   int checks = 0;
   int errors = 0;

   mod_rst_seq #(
      .SYNC_STAGES (SYNC),
      .LOCK_CYCLES (LOCK),
      .N_OUT       (NOUT),
      .STAGE_GAP   (GAP),
      .LOSS_CNT_W  (LOSSW)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_pll_locked (lock),
      .o_rst_n      (o_rst_n),
      .o_ready      (o_ready),
      .o_state      (o_state)
`ifdef RST_SEQ_LOSS_CNT_EN
      ,
      .o_loss_cnt   (o_loss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: lock sample history and the current run length.
   logic [SYNC-1:0] m_hist;
   int              m_r;
   int              m_loss;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hist <= '0;
         m_r    <= 0;
         m_loss <= 0;
      end else begin
         m_hist <= {m_hist[SYNC-2:0], lock};
         if (m_hist[SYNC-1]) m_r <= (m_r < 100000) ? m_r + 1 : m_r;
         else                m_r <= 0;
         if (!m_hist[SYNC-1] && m_r >= RUN_R && m_loss < LOSS_MAX)
            m_loss <= m_loss + 1;
      end
   end

   function automatic logic [1:0] m_state(input int r);
      if (r == 0)          return 2'd0;
      else if (r < REL0_R) return 2'd1;
      else if (r < RUN_R)  return 2'd2;
      else                 return 2'd3;
   endfunction

   function automatic logic [NOUT-1:0] m_rst(input int r);
      logic [NOUT-1:0] v;
      v = '0;
      for (int k = 0; k < NOUT; k++)
         if (r >= REL0_R + k * GAP) v[k] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      chk({tag, " o_state"}, 32'(o_state), 32'(m_state(m_r)));
      chk({tag, " o_rst_n"}, 32'(o_rst_n), 32'(m_rst(m_r)));
      chk({tag, " o_ready"}, 32'(o_ready), 32'(m_r >= RUN_R + 1));
`ifdef RST_SEQ_LOSS_CNT_EN
      chk({tag, " o_loss_cnt"}, 32'(o_loss_cnt), 32'(m_loss));
`endif
   endtask

   // Asynchronous reset pulse between clock edges; outputs checked while low.
   task automatic async_reset_pulse(input string tag);
      #1 rst_n = 1'b0;
      #1;
      chk({tag, " async o_rst_n"}, 32'(o_rst_n), 32'd0);
      chk({tag, " async o_ready"}, 32'(o_ready), 32'd0);
      chk({tag, " async o_state"}, 32'(o_state), 32'd0);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic       lk;
      int         edges;
      logic [1:0] rst;
      logic       rdy;
      logic [1:0] st;
   } vec_t;

   vec_t vecs[$];

   initial begin
      rst_n = 1'b0;
      lock  = 1'b0;

      // Reset state.
      tick();
      chk("reset o_rst_n", 32'(o_rst_n), 32'd0);
      chk("reset o_ready", 32'(o_ready), 32'd0);
      chk("reset o_state", 32'(o_state), 32'd0);
      rst_n = 1'b1;
      repeat (4) tick();

      // Clean lock: lock sampled from edge 1.
      vecs.push_back('{1'b1, 10, 2'b00, 1'b0, 2'd1});
      vecs.push_back('{1'b1,  1, 2'b01, 1'b0, 2'd2});
      vecs.push_back('{1'b1,  3, 2'b01, 1'b0, 2'd2});
      vecs.push_back('{1'b1,  1, 2'b11, 1'b0, 2'd3});
      vecs.push_back('{1'b1,  1, 2'b11, 1'b1, 2'd3});
      // Loss in S_RUN, then identical re-sequence.
      vecs.push_back('{1'b0,  2, 2'b11, 1'b1, 2'd3});
      vecs.push_back('{1'b0,  1, 2'b00, 1'b0, 2'd0});
      vecs.push_back('{1'b0,  3, 2'b00, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 10, 2'b00, 1'b0, 2'd1});
      vecs.push_back('{1'b1,  1, 2'b01, 1'b0, 2'd2});
      vecs.push_back('{1'b1,  4, 2'b11, 1'b0, 2'd3});
      vecs.push_back('{1'b1,  1, 2'b11, 1'b1, 2'd3});
      // Loss in S_RELEASE; the drop reaches the FSM on the bit-1 release edge.
      vecs.push_back('{1'b0,  6, 2'b00, 1'b0, 2'd0});
      vecs.push_back('{1'b1, 11, 2'b01, 1'b0, 2'd2});
      vecs.push_back('{1'b1,  1, 2'b01, 1'b0, 2'd2});
      vecs.push_back('{1'b0,  2, 2'b01, 1'b0, 2'd2});
      vecs.push_back('{1'b0,  1, 2'b00, 1'b0, 2'd0});
      vecs.push_back('{1'b0,  5, 2'b00, 1'b0, 2'd0});
      // Glitch: 5 high, 1 low, then high again.
      vecs.push_back('{1'b1,  5, 2'b00, 1'b0, 2'd1});
      vecs.push_back('{1'b0,  1, 2'b00, 1'b0, 2'd1});
      vecs.push_back('{1'b1,  2, 2'b00, 1'b0, 2'd0});
      vecs.push_back('{1'b1,  8, 2'b00, 1'b0, 2'd1});
      vecs.push_back('{1'b1,  1, 2'b01, 1'b0, 2'd2});
      vecs.push_back('{1'b1,  4, 2'b11, 1'b0, 2'd3});
      vecs.push_back('{1'b1,  1, 2'b11, 1'b1, 2'd3});

      foreach (vecs[i]) begin
         lock = vecs[i].lk;
         repeat (vecs[i].edges) tick();
         chk($sformatf("vec%0d o_rst_n", i), 32'(o_rst_n), 32'(vecs[i].rst));
         chk($sformatf("vec%0d o_ready", i), 32'(o_ready), 32'(vecs[i].rdy));
         chk($sformatf("vec%0d o_state", i), 32'(o_state), 32'(vecs[i].st));
      end

      // Async reset mid-S_RUN with lock held high: full restart afterwards.
      async_reset_pulse("mid_run");
      repeat (10) tick();
      chk("post_reset e10 o_rst_n", 32'(o_rst_n), 32'd0);
      tick();
      chk("post_reset e11 o_rst_n", 32'(o_rst_n), 32'd1);
`ifdef RST_SEQ_LOSS_CNT_EN
      chk("post_reset o_loss_cnt", 32'(o_loss_cnt), 32'd0);
`endif
      repeat (4) tick();
      chk("post_reset e15 o_rst_n", 32'(o_rst_n), 32'd3);
      tick();
      chk("post_reset e16 o_ready", 32'(o_ready), 32'd1);

`ifdef RST_SEQ_LOSS_CNT_EN
      // Five losses from S_RUN saturate at 3; a loss from S_FILTER is ignored.
      for (int n = 1; n <= 5; n++) begin
         lock = 1'b0;
         repeat (4) tick();
         chk($sformatf("loss%0d o_loss_cnt", n), 32'(o_loss_cnt),
             32'((n > LOSS_MAX) ? LOSS_MAX : n));
         lock = 1'b1;
         repeat (16) tick();
         chk($sformatf("loss%0d relock o_ready", n), 32'(o_ready), 32'd1);
      end
      lock = 1'b0;
      repeat (4) tick();
      lock = 1'b1;
      repeat (5) tick();
      chk("filter o_state", 32'(o_state), 32'd1);
      lock = 1'b0;
      repeat (4) tick();
      chk("filter loss o_loss_cnt", 32'(o_loss_cnt), 32'(LOSS_MAX));
      chk("filter loss o_state", 32'(o_state), 32'd0);
`endif

      // Random lock toggling with occasional async resets, against the model.
      for (int s = 0; s < 160; s++) begin
         int hold;
         lock = ~lock;
         hold = int'($urandom_range(1, 30));
         for (int c = 0; c < hold; c++) begin
            if ($urandom_range(0, 199) == 0) async_reset_pulse("rand");
            tick();
            check_model("rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
